emu_time_mgr: RTL and testbench
===============================

EMU_TIME_MGR -- requirements
Module: emu_time_mgr

Interface
REQ-001 The block SHALL have one clock, emu_clk; reset emu_rst SHALL be asynchronous and active-high.
REQ-002 Parameter TIME_WIDTH, default 40: width of emulated time in integer ticks.
REQ-003 Parameter DT_WIDTH, default 32: width of per-cycle timestep in ticks.
REQ-004 emu_clk  input  1  emulator clock.
REQ-005 emu_rst  input  1  async active-high reset.
REQ-006 cmd_valid  input  1  controller command present.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising emu_clk.
REQ-008 cmd_op  input  2  0=SLEEP (relative), 1=RUN_TO (absolute stop time), 2=ABORT, 3=reserved (ignored, accepted as no-op).
REQ-009 cmd_data  input  TIME_WIDTH  SLEEP duration or RUN_TO stop time, in ticks.
REQ-010 dt_req  input  DT_WIDTH  timestep requested by the analog models this cycle.
REQ-011 emu_dt  output  DT_WIDTH  granted timestep applied this cycle.
REQ-012 emu_time  output  TIME_WIDTH  current emulated time.
REQ-013 emu_stall  output  1  high when models must hold state (emu_dt==0 by grant).
REQ-014 done  output  1  one-cycle pulse when a sleep/run completes.
REQ-015 time_sat  output  1  sticky: emu_time or stop target saturated.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE: emu_stall=1, emu_dt=0, cmd_ready=1.
REQ-018 IDLE + accepted SLEEP: stop_time = emu_time + cmd_data, saturating at 2^TIME_WIDTH-1 (sets time_sat); go to RUN, or directly to DONE if cmd_data==0.
REQ-019 IDLE + accepted RUN_TO: stop_time = cmd_data; if cmd_data <= emu_time go to DONE, else RUN.
REQ-020 IDLE + ABORT or op 3: accepted, no state change.
REQ-021 RUN: emu_stall=0; emu_dt = min(dt_req, stop_time - emu_time), combinational, zero-latency.
REQ-022 RUN: emu_time <= emu_time + emu_dt each cycle; emu_time SHALL never exceed stop_time.
REQ-023 RUN: when emu_time + emu_dt == stop_time, next state DONE.
REQ-024 RUN with dt_req==0: emu_time holds, state stays RUN, emu_stall stays 0.
REQ-025 RUN: cmd_ready = (cmd_op==ABORT); accepted ABORT forces IDLE next cycle; emu_time update of that cycle still applies.
REQ-026 DONE: done=1, emu_stall=1, emu_dt=0, cmd_ready=0 for exactly one cycle, then IDLE.
REQ-027 stop_time - emu_time wider than DT_WIDTH SHALL clamp to 2^DT_WIDTH-1 before the min.
REQ-028 time_sat clears only on reset.

Reset
REQ-029 On emu_rst assertion, immediately: state=IDLE, emu_time=0, stop_time=0, time_sat=0, done=0, emu_stall=1, emu_dt=0, cmd_ready=1.
REQ-030 Reset mid-RUN SHALL discard the pending target; no done pulse is produced.
REQ-031 After deassertion, no time advances until a command is accepted.

Structure
REQ-032 Package emu_time_pkg SHALL hold the state enum, cmd_op encodings, and default TIME_WIDTH/DT_WIDTH constants.
REQ-033 Sub-module dt_clamp SHALL implement the combinational saturating remaining-time and min computation (REQ-021, REQ-027).

Verification
REQ-034 Reset, then SLEEP 100, with dt_req=10 constant -> 10 RUN cycles, emu_time 0..100 in steps of 10, done pulses once, then IDLE with emu_stall=1.
REQ-035 SLEEP 25 with dt_req=10 -> emu_dt sequence 10,10,5; emu_time ends at exactly 25.
REQ-036 RUN_TO 50 from emu_time=80 -> DONE next cycle, emu_time unchanged at 80; SLEEP 0 -> immediate done.
REQ-037 SLEEP 1000, dt_req=7, ABORT after 3 RUN cycles -> emu_time=21 or 28 per REQ-025, IDLE, no done pulse.
REQ-038 emu_time near 2^TIME_WIDTH-5, SLEEP 100 -> stop_time saturates, time_sat=1, emu_time stops at 2^TIME_WIDTH-1.
REQ-039 Assert emu_rst asynchronously mid-RUN -> all outputs at reset values without waiting for emu_clk edge.

Source files
------------

// File: rtl/emu_time_pkg.sv
// Shared types and encodings for the emulated-time manager.
// Default widths size emulated time in integer ticks and the per-cycle step.
package emu_time_pkg;

    localparam int TIME_WIDTH_DEF = 40;
    localparam int DT_WIDTH_DEF   = 32;

    localparam logic [1:0] OP_SLEEP  = 2'd0;
    localparam logic [1:0] OP_RUN_TO = 2'd1;
    localparam logic [1:0] OP_ABORT  = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dt_clamp.sv
// Grants min(dt_req, stop - time), with the remaining time saturated to the
// timestep width so a far-away target never wraps into a small step.
module dt_clamp #(
    parameter int TIME_WIDTH = 40,
    parameter int DT_WIDTH   = 32
) (
    input  logic [TIME_WIDTH-1:0] time_i,
    input  logic [TIME_WIDTH-1:0] stop_i,
    input  logic [DT_WIDTH-1:0]   dt_req_i,
    output logic [DT_WIDTH-1:0]   dt_o
);

    localparam int W = (TIME_WIDTH > DT_WIDTH) ? TIME_WIDTH : DT_WIDTH;

    logic [W-1:0]        time_w;
    logic [W-1:0]        stop_w;
    logic [W-1:0]        remain_w;
    logic [W-1:0]        dt_max_w;
    logic [DT_WIDTH-1:0] remain_clamped;

    always_comb begin
        time_w   = W'(time_i);
        stop_w   = W'(stop_i);
        dt_max_w = W'({DT_WIDTH{1'b1}});
        // A target behind the current time grants nothing rather than wrapping.
        remain_w = (stop_w > time_w) ? (stop_w - time_w) : '0;
        remain_clamped = (remain_w > dt_max_w) ? {DT_WIDTH{1'b1}}
                                               : remain_w[DT_WIDTH-1:0];
        dt_o = (dt_req_i < remain_clamped) ? dt_req_i : remain_clamped;
    end

endmodule

// File: rtl/emu_time_mgr.sv
// Emulated-time manager: advances emulated time toward a commanded stop time
// by the timestep the analog models request, never overshooting the target.
//
// state   | meaning
// IDLE    | time frozen, models stalled, any command accepted
// RUN     | time advances by granted dt each cycle; only ABORT accepted
// DONE    | one-cycle completion pulse, then back to IDLE
module emu_time_mgr
    import emu_time_pkg::*;
#(
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int DT_WIDTH   = DT_WIDTH_DEF
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [TIME_WIDTH-1:0] cmd_data,
    input  logic [DT_WIDTH-1:0]   dt_req,
    output logic [DT_WIDTH-1:0]   emu_dt,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic                  emu_stall,
    output logic                  done,
    output logic                  time_sat
);

    state_e                state_q, state_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [TIME_WIDTH-1:0] stop_q, stop_d;
    logic                  sat_q, sat_d;

    logic [DT_WIDTH-1:0]   grant;
    logic [TIME_WIDTH:0]   sleep_sum;
    logic [TIME_WIDTH-1:0] run_next;

    dt_clamp #(
        .TIME_WIDTH (TIME_WIDTH),
        .DT_WIDTH   (DT_WIDTH)
    ) u_dt_clamp (
        .time_i   (time_q),
        .stop_i   (stop_q),
        .dt_req_i (dt_req),
        .dt_o     (grant)
    );

    assign sleep_sum = {1'b0, time_q} + {1'b0, cmd_data};
    assign run_next  = time_q + TIME_WIDTH'(grant);
    assign emu_time  = time_q;
    assign time_sat  = sat_q;

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            stop_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            stop_q  <= stop_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        stop_d    = stop_q;
        sat_d     = sat_q;
        cmd_ready = 1'b0;
        emu_dt    = '0;
        emu_stall = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_SLEEP: begin
                            if (sleep_sum[TIME_WIDTH]) begin
                                stop_d = '1;
                                sat_d  = 1'b1;
                            end else begin
                                stop_d = sleep_sum[TIME_WIDTH-1:0];
                            end
                            state_d = (cmd_data == '0) ? ST_DONE : ST_RUN;
                        end
                        OP_RUN_TO: begin
                            stop_d  = cmd_data;
                            state_d = (cmd_data <= time_q) ? ST_DONE : ST_RUN;
                        end
                        OP_ABORT, OP_RSVD: ;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                emu_stall = 1'b0;
                emu_dt    = grant;
                cmd_ready = (cmd_op == OP_ABORT);
                time_d    = run_next;
                // Abort wins over reaching the target: no done pulse on abort.
                if (cmd_valid && (cmd_op == OP_ABORT)) begin
                    state_d = ST_IDLE;
                end else if (run_next == stop_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_emu_time_mgr.sv
// Scoreboard bench for emu_time_mgr: directed commands push expected RUN/DONE
// cycles; a negedge monitor pops and compares whenever the DUT presents one.
module tb_emu_time_mgr;
    import emu_time_pkg::*;

    localparam int TW = 40;
    localparam int DW = 32;
    localparam logic [TW-1:0] TMAX  = {TW{1'b1}};
    localparam logic [DW-1:0] DTMAX = {DW{1'b1}};

    logic          emu_clk = 1'b0;
    logic          emu_rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [TW-1:0] cmd_data = '0;
    logic [DW-1:0] dt_req = '0;
    logic [DW-1:0] emu_dt;
    logic [TW-1:0] emu_time;
    logic          emu_stall;
    logic          done;
    logic          time_sat;

    typedef struct {
        bit            is_done;
        logic [DW-1:0] dt;
        logic [TW-1:0] t;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    emu_time_mgr #(.TIME_WIDTH(TW), .DT_WIDTH(DW)) dut (
        .emu_clk   (emu_clk),
        .emu_rst   (emu_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .dt_req    (dt_req),
        .emu_dt    (emu_dt),
        .emu_time  (emu_time),
        .emu_stall (emu_stall),
        .done      (done),
        .time_sat  (time_sat)
    );

    always #5 emu_clk = ~emu_clk;

    // Monitor: every RUN cycle (stall low) or done pulse must match the queue head.
    always @(negedge emu_clk) begin
        if (!emu_rst && (!emu_stall || done)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output done=%0b dt=%0d time=%0d required none",
                         done, emu_dt, emu_time);
            end else begin
                e = q.pop_front();
                if ((done !== e.is_done) || (emu_dt !== e.dt) || (emu_time !== e.t) ||
                    (done && (cmd_ready !== 1'b0 || emu_stall !== 1'b1))) begin
                    errors++;
                    $display("FAIL scoreboard done=%0b dt=%0d time=%0d ready=%0b required done=%0b dt=%0d time=%0d",
                             done, emu_dt, emu_time, cmd_ready, e.is_done, e.dt, e.t);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input bit d, input logic [DW-1:0] dt, input logic [TW-1:0] t);
        exp_t x;
        x.is_done = d;
        x.dt      = dt;
        x.t       = t;
        q.push_back(x);
    endtask

    task automatic issue(input logic [1:0] op, input logic [TW-1:0] data);
        @(posedge emu_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge emu_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge emu_clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout remaining=%0d required=0", q.size());
            q.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge emu_clk);
        #1;
        emu_rst = 1'b1;
        repeat (2) @(posedge emu_clk);
        #1;
        emu_rst = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] acc;

        // Reset values, checked before any clock edge.
        #1;
        chk("rst_stall", emu_stall, 1);
        chk("rst_dt", emu_dt, 0);
        chk("rst_time", emu_time, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_sat", time_sat, 0);
        repeat (2) @(posedge emu_clk);
        #1;
        emu_rst = 1'b0;
        dt_req  = 10;
        repeat (3) @(posedge emu_clk);
        #1;
        chk("no_advance_idle", emu_time, 0);

        // SLEEP 100, dt 10: ten RUN cycles then done at 100.
        for (int k = 0; k < 10; k++) push(0, 10, TW'(10 * k));
        push(1, 0, 100);
        issue(OP_SLEEP, 100);
        drain(40);
        chk("idle_stall", emu_stall, 1);
        chk("idle_time", emu_time, 100);
        chk("idle_ready", cmd_ready, 1);

        // SLEEP 25 from 0: dt 10,10,5.
        do_reset();
        push(0, 10, 0); push(0, 10, 10); push(0, 5, 20); push(1, 0, 25);
        issue(OP_SLEEP, 25);
        drain(20);
        chk("sleep25_time", emu_time, 25);

        // SLEEP 55 brings time to 80.
        push(0, 10, 25); push(0, 10, 35); push(0, 10, 45);
        push(0, 10, 55); push(0, 10, 65); push(0, 5, 75); push(1, 0, 80);
        issue(OP_SLEEP, 55);
        drain(20);

        // RUN_TO into the past and SLEEP 0 both complete immediately.
        push(1, 0, 80);
        issue(OP_RUN_TO, 50);
        drain(10);
        chk("runto_past_time", emu_time, 80);
        push(1, 0, 80);
        issue(OP_SLEEP, 0);
        drain(10);

        // RUN_TO 90 with dt 4.
        dt_req = 4;
        push(0, 4, 80); push(0, 4, 84); push(0, 2, 88); push(1, 0, 90);
        issue(OP_RUN_TO, 90);
        drain(20);

        // dt_req 0 holds time in RUN without stalling.
        dt_req = 0;
        push(0, 0, 90); push(0, 0, 90); push(0, 0, 90);
        push(0, 6, 90); push(0, 4, 96); push(1, 0, 100);
        issue(OP_SLEEP, 10);
        repeat (3) @(posedge emu_clk);
        #1;
        dt_req = 6;
        drain(20);

        // ABORT presented on the fourth RUN cycle; that cycle's step still lands.
        dt_req = 7;
        push(0, 7, 100); push(0, 7, 107); push(0, 7, 114); push(0, 7, 121);
        issue(OP_SLEEP, 1000);
        repeat (2) @(posedge emu_clk);
        issue(OP_ABORT, 0);
        repeat (5) @(posedge emu_clk);
        #1;
        chk("abort_time", emu_time, 128);
        chk("abort_stall", emu_stall, 1);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_queue", q.size(), 0);

        // Reserved op and ABORT in IDLE are no-ops.
        issue(OP_RSVD, 500);
        issue(OP_ABORT, 0);
        repeat (3) @(posedge emu_clk);
        #1;
        chk("noop_time", emu_time, 128);
        chk("noop_stall", emu_stall, 1);

        // Large RUN_TO: remaining time beyond DT range clamps to max dt.
        do_reset();
        chk("sat_after_reset", time_sat, 0);
        dt_req = DTMAX;
        acc = '0;
        for (int k = 0; k < 256; k++) begin
            push(0, DTMAX, acc);
            acc = acc + TW'(DTMAX);
        end
        push(0, 251, acc);
        push(1, 0, TMAX - 4);
        issue(OP_RUN_TO, TMAX - 4);
        drain(400);
        chk("near_max_time", emu_time, TMAX - 4);
        chk("near_max_sat", time_sat, 0);

        // SLEEP 100 near the top saturates the target.
        dt_req = 10;
        push(0, 4, TMAX - 4); push(1, 0, TMAX);
        issue(OP_SLEEP, 100);
        drain(20);
        chk("sat_time", emu_time, TMAX);
        chk("sat_flag", time_sat, 1);
        push(0, 0, TMAX); push(1, 0, TMAX);
        issue(OP_SLEEP, 5);
        drain(20);
        chk("sat_sticky", time_sat, 1);
        chk("sat_time_hold", emu_time, TMAX);

        // Asynchronous reset mid-RUN.
        do_reset();
        chk("sat_cleared", time_sat, 0);
        dt_req = 7;
        push(0, 7, 0); push(0, 7, 7);
        issue(OP_SLEEP, 1000);
        @(posedge emu_clk);
        @(posedge emu_clk);
        #2;
        emu_rst = 1'b1;
        #1;
        chk("async_stall", emu_stall, 1);
        chk("async_dt", emu_dt, 0);
        chk("async_time", emu_time, 0);
        chk("async_ready", cmd_ready, 1);
        chk("async_done", done, 0);
        repeat (2) @(posedge emu_clk);
        #1;
        emu_rst = 1'b0;
        repeat (5) @(posedge emu_clk);
        #1;
        chk("post_reset_time", emu_time, 0);
        chk("post_reset_queue", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
